dh_exp_core: RTL and testbench

//  Diffie-Hellman arithmetic core. Wraps two sub-blocks: a 13-bit LFSR that

---
 rtl/dh_pkg.sv | 17 +
 rtl/lfsr.sv | 35 +++
 rtl/modmul.sv | 64 ++++++
 rtl/modular_exp.sv | 121 ++++++++++++
 rtl/dh_exp_core.sv | 38 +++
 tb/tb_dh_exp_core.sv | 235 +++++++++++++++++++++++
 6 files changed

// File: rtl/dh_pkg.sv
// Shared constants and types for the Diffie-Hellman arithmetic core.
// Holds the operand width, the LFSR seed and taps, and the exponentiator states.
package dh_pkg;
    localparam int LEN    = 100;
    localparam int LFSR_W = 13;

    localparam logic [LFSR_W-1:0] LFSR_SEED = 13'h1ACE;
    // Feedback taps at bits 12,3,2,0: x^13+x^4+x^3+x+1 (maximal length)
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 13'h100D;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REDUCE = 2'd1,
        ST_LOOP   = 2'd2,
        ST_DONE   = 2'd3
    } exp_state_t;
endpackage

// File: rtl/lfsr.sv
// Seeded 13-bit Fibonacci LFSR that supplies secret exponent bits.
// lfsr_done rises once the register has shifted LFSR_W times after reset.
module lfsr
    import dh_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        seed_no,
    output logic              lfsr_done,
    output logic [LFSR_W-1:0] lfsr
);
    localparam int WARM_W = $clog2(LFSR_W + 1);

    logic [LFSR_W-1:0] lfsr_reg;
    logic [WARM_W-1:0] warm_reg;
    logic              done_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_reg <= LFSR_SEED ^ {{(LFSR_W-3){1'b0}}, seed_no};
            warm_reg <= '0;
            done_reg <= 1'b0;
        end else begin
            lfsr_reg <= {lfsr_reg[LFSR_W-2:0], ^(lfsr_reg & LFSR_TAPS)};
            if (!done_reg) begin
                warm_reg <= warm_reg + 1'b1;
                if (warm_reg == WARM_W'(LFSR_W - 1))
                    done_reg <= 1'b1;
            end
        end
    end

    assign lfsr      = lfsr_reg;
    assign lfsr_done = done_reg;
endmodule

// File: rtl/modmul.sv
// Bit-serial interleaved modular multiplier: prod = a*b mod p, needs b<p.
// Reset arms it for a new product; load starts one and performs its first step.
module modmul
    import dh_pkg::*;
#(
    parameter int OP_W = LEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [OP_W-1:0] a,
    input  logic [OP_W-1:0] b,
    input  logic [OP_W-1:0] p,
    output logic [OP_W-1:0] prod,
    output logic            done
);
    localparam int CNT_W = $clog2(OP_W + 1);
    localparam int IDX_W = $clog2(OP_W);

    logic [OP_W+1:0]  acc_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [OP_W+1:0]  acc_in;
    logic [OP_W+1:0]  sum;
    logic [OP_W+1:0]  acc_next;
    logic [IDX_W-1:0] idx;
    logic             a_bit;

    function automatic logic [OP_W+1:0] mod_sub(input logic [OP_W+1:0] x,
                                                input logic [OP_W+1:0] m);
        return (x >= m) ? x - m : x;
    endfunction

    always_comb begin
        acc_in = load ? '0 : acc_reg;
        idx    = '0;
        a_bit  = 1'b0;
        if (load) begin
            idx   = IDX_W'(OP_W - 1);
            a_bit = a[idx];
        end else if (cnt_reg != '0) begin
            idx   = IDX_W'(cnt_reg - 1'b1);
            a_bit = a[idx];
        end
        // 2*acc + b stays below 3p, so two conditional subtractions suffice
        sum      = (acc_in << 1) + (a_bit ? {2'b00, b} : '0);
        acc_next = mod_sub(mod_sub(sum, {2'b00, p}), {2'b00, p});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_reg <= '0;
            cnt_reg <= CNT_W'(OP_W);
        end else if (load) begin
            acc_reg <= acc_next;
            cnt_reg <= CNT_W'(OP_W - 1);
        end else if (cnt_reg != '0) begin
            acc_reg <= acc_next;
            cnt_reg <= cnt_reg - 1'b1;
        end
    end

    assign prod = acc_reg[OP_W-1:0];
    assign done = (cnt_reg == '0);
endmodule

// File: rtl/modular_exp.sv
// Right-to-left square-and-multiply exponentiator: result = base^exp_in mod prime.
// start acts as an asynchronous clear that also captures the operands.
module modular_exp
    import dh_pkg::*;
#(
    parameter int OP_W = LEN
) (
    input  logic            clk,
    input  logic            start,
    input  logic [OP_W-1:0] base,
    input  logic [OP_W:0]   exp_in,
    input  logic [OP_W-1:0] prime,
    output logic [OP_W-1:0] result,
    output logic            dirty0,
    output logic            dirty1
);
    exp_state_t      state_reg;
    logic [OP_W-1:0] base_reg;
    logic [OP_W-1:0] prime_reg;
    logic [OP_W:0]   e_reg;
    logic [OP_W-1:0] r_reg;
    logic [OP_W-1:0] b_reg;
    logic [OP_W-1:0] result_reg;
    logic            mul_run_reg;
    logic            dirty0_reg;
    logic            dirty1_reg;

    logic [OP_W-1:0] mul_a    [2];
    logic [OP_W-1:0] mul_b    [2];
    logic [OP_W-1:0] mul_prod [2];
    logic            mul_done [2];
    logic            mul_load;
    logic            step_done;
    logic            reducing;

    assign reducing  = (state_reg == ST_REDUCE);
    assign mul_load  = (state_reg == ST_LOOP) && !mul_run_reg;
    assign step_done = mul_done[0] && mul_done[1];

    // Unit 0 accumulates R*B; unit 1 reduces the base, then squares B
    assign mul_a[0] = r_reg;
    assign mul_b[0] = b_reg;
    assign mul_a[1] = reducing ? base_reg : b_reg;
    assign mul_b[1] = reducing ? OP_W'(1) : b_reg;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_mul
            modmul #(.OP_W(OP_W)) u_mul (
                .clk  (clk),
                .rst  (start),
                .load (mul_load),
                .a    (mul_a[gi]),
                .b    (mul_b[gi]),
                .p    (prime_reg),
                .prod (mul_prod[gi]),
                .done (mul_done[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge start) begin
        if (start) begin
            base_reg    <= base;
            prime_reg   <= prime;
            e_reg       <= exp_in;
            state_reg   <= ST_REDUCE;
            mul_run_reg <= 1'b0;
            dirty0_reg  <= 1'b1;
            dirty1_reg  <= 1'b1;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    dirty0_reg <= 1'b0;
                    dirty1_reg <= 1'b0;
                end
                ST_REDUCE: begin
                    if (step_done)
                        state_reg <= (e_reg == '0) ? ST_DONE : ST_LOOP;
                end
                ST_LOOP: begin
                    if (!mul_run_reg) begin
                        mul_run_reg <= 1'b1;
                    end else if (step_done) begin
                        mul_run_reg <= 1'b0;
                        e_reg       <= e_reg >> 1;
                        // Test the shifted exponent now to save a cycle per run
                        if (e_reg[OP_W:1] == '0)
                            state_reg <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    dirty0_reg <= 1'b0;
                    dirty1_reg <= 1'b0;
                    state_reg  <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Datapath registers hold while start is asserted; result is never cleared
    always_ff @(posedge clk) begin
        if (!start) begin
            if (reducing && step_done) begin
                b_reg <= mul_prod[1];
                r_reg <= OP_W'(1);
            end
            if (state_reg == ST_LOOP && mul_run_reg && step_done) begin
                b_reg <= mul_prod[1];
                if (e_reg[0])
                    r_reg <= mul_prod[0];
            end
            if (state_reg == ST_DONE)
                result_reg <= r_reg;
        end
    end

    assign result = result_reg;
    assign dirty0 = dirty0_reg;
    assign dirty1 = dirty1_reg;
endmodule

// File: rtl/dh_exp_core.sv
// Diffie-Hellman core: secret-exponent LFSR plus modular exponentiator.
// One instance per key-exchange partner.
module dh_exp_core #(
    parameter int LEN    = dh_pkg::LEN,
    parameter int LFSR_W = dh_pkg::LFSR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        seed_no,
    output logic              lfsr_done,
    output logic [LFSR_W-1:0] lfsr,
    input  logic              start,
    input  logic [LEN-1:0]    base,
    input  logic [LEN:0]      exp_in,
    input  logic [LEN-1:0]    prime,
    output logic [LEN-1:0]    result,
    output logic              dirty0,
    output logic              dirty1
);
    lfsr u_lfsr (
        .clk       (clk),
        .rst       (rst),
        .seed_no   (seed_no),
        .lfsr_done (lfsr_done),
        .lfsr      (lfsr)
    );

    modular_exp #(.OP_W(LEN)) u_exp (
        .clk    (clk),
        .start  (start),
        .base   (base),
        .exp_in (exp_in),
        .prime  (prime),
        .result (result),
        .dirty0 (dirty0),
        .dirty1 (dirty1)
    );
endmodule

// File: tb/tb_dh_exp_core.sv
// Scoreboard bench for dh_exp_core: LFSR sequence/period and modular exponentiation.
// Expected results are queued at stimulus time and popped when dirty clears.
module tb_dh_exp_core;
    localparam int L = dh_pkg::LEN;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [2:0]     seed_no = 3'd0;
    logic           lfsr_done;
    logic [12:0]    lfsr;
    logic           start = 1'b0;
    logic [L-1:0]   base = '0;
    logic [L:0]     exp_in = '0;
    logic [L-1:0]   prime = '0;
    logic [L-1:0]   result;
    logic           dirty0, dirty1;

    int             n_tests = 0;
    int             n_fail  = 0;
    logic [L-1:0]   exp_q[$];
    logic [L-1:0]   last_result = '0;
    bit             last_known = 1'b0;

    always #5 clk = ~clk;

    dh_exp_core dut (
        .clk       (clk),
        .rst       (rst),
        .seed_no   (seed_no),
        .lfsr_done (lfsr_done),
        .lfsr      (lfsr),
        .start     (start),
        .base      (base),
        .exp_in    (exp_in),
        .prime     (prime),
        .result    (result),
        .dirty0    (dirty0),
        .dirty1    (dirty1)
    );

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("[TB] FAIL %s got=0x%0h want=0x%0h", tag, got, want);
        end
    endtask

    function automatic logic [12:0] lfsr_step(input logic [12:0] s);
        return {s[11:0], s[12] ^ s[3] ^ s[2] ^ s[0]};
    endfunction

    function automatic logic [L-1:0] ref_modexp(input logic [L-1:0] b, input logic [L:0] e,
                                                input logic [L-1:0] p);
        logic [255:0] r, bb, pp;
        logic [L:0]   ee;
        pp = 256'(p);
        r  = 256'd1;
        bb = 256'(b) % pp;
        ee = e;
        while (ee != '0) begin
            if (ee[0]) r = (r * bb) % pp;
            bb = (bb * bb) % pp;
            ee = ee >> 1;
        end
        return r[L-1:0];
    endfunction

    function automatic int nbits(input logic [L:0] e);
        int n = 0;
        logic [L:0] t = e;
        while (t != '0) begin
            n++;
            t = t >> 1;
        end
        return n;
    endfunction

    task automatic start_op(input logic [L-1:0] b, input logic [L:0] e, input logic [L-1:0] p);
        @(negedge clk);
        base   = b;
        exp_in = e;
        prime  = p;
        start  = 1'b1;
        #1;
        check_val("dirty_on_start", 128'({dirty0, dirty1}), 128'(2'b11));
        if (last_known) check_val("result_hold", 128'(result), 128'(last_result));
        @(negedge clk);
        start  = 1'b0;
        // Scramble live inputs: only the captured operands may matter
        base   = L'({$urandom(), $urandom(), $urandom(), $urandom()});
        exp_in = (L+1)'({$urandom(), $urandom(), $urandom(), $urandom()});
        prime  = L'({$urandom(), $urandom(), $urandom(), $urandom()});
    endtask

    task automatic wait_done(input string tag, input int k_bits, input bit cmp);
        int bound = L + k_bits * (L + 1) + 2;
        int cyc = 0;
        int bad = 0;
        logic [L-1:0] want;
        while (dirty0 === 1'b1 && cyc < bound + 20) begin
            @(negedge clk);
            cyc++;
            if (dirty0 !== dirty1) bad++;
        end
        check_val({tag, "_dirty_clear"}, 128'(dirty0), 128'(0));
        check_val({tag, "_latency"}, 128'(cyc <= bound), 128'(1));
        check_val({tag, "_dirty_copy"}, 128'(bad), 128'(0));
        if (cmp) begin
            check_val({tag, "_sb_nonempty"}, 128'(exp_q.size() > 0), 128'(1));
            want = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            check_val(tag, 128'(result), 128'(want));
            last_result = want;
            last_known  = 1'b1;
        end else begin
            last_known  = 1'b0;
        end
        $display("[TB] %s result=0x%0h cycles=%0d bound=%0d", tag, result, cyc, bound);
    endtask

    task automatic run_vec(input string tag, input logic [L-1:0] b, input logic [L:0] e,
                           input logic [L-1:0] p, input logic [L-1:0] want);
        exp_q.push_back(want);
        start_op(b, e, p);
        wait_done(tag, nbits(e), 1'b1);
    endtask

    initial begin
        #4_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [12:0]  model;
        logic [L-1:0] m89;
        logic [L-1:0] primes [5];
        logic [L-1:0] rb, rp;
        logic [L:0]   re;
        int mism, zeros, period, done_edge, done_drop, bad;

        #1;
        check_val("pwrup_dirty", 128'({dirty0, dirty1}), 128'(0));
        check_val("pwrup_result", 128'(result), 128'(0));

        // LFSR with seed 0
        #1 rst = 1'b1;
        #1;
        check_val("lfsr_seed0", 128'(lfsr), 128'(13'h1ACE));
        check_val("lfsr_done_rst", 128'(lfsr_done), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        model = 13'h1ACE;
        mism = 0; zeros = 0; period = 0; done_edge = 0; done_drop = 0;
        for (int i = 1; i <= 8200 && period == 0; i++) begin
            @(negedge clk);
            model = lfsr_step(model);
            if (lfsr !== model) mism++;
            if (lfsr == 13'h0) zeros++;
            if (lfsr == 13'h1ACE) period = i;
            if (lfsr_done === 1'b1 && done_edge == 0) done_edge = i;
            if (lfsr_done !== 1'b1 && done_edge != 0) done_drop++;
        end
        check_val("lfsr_seq", 128'(mism), 128'(0));
        check_val("lfsr_done_edge", 128'(done_edge), 128'(13));
        check_val("lfsr_done_stays", 128'(done_drop), 128'(0));
        check_val("lfsr_no_zero", 128'(zeros), 128'(0));
        check_val("lfsr_period", 128'(period), 128'(8191));
        $display("[TB] lfsr seed0 period=%0d done_edge=%0d", period, done_edge);

        // LFSR with seed 1, asynchronous reset mid-cycle
        #2 seed_no = 3'd1;
        rst = 1'b1;
        #1;
        check_val("lfsr_seed1", 128'(lfsr), 128'(13'h1ACF));
        check_val("lfsr_done_rst1", 128'(lfsr_done), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        model = 13'h1ACF;
        repeat (13) begin
            @(negedge clk);
            model = lfsr_step(model);
        end
        check_val("lfsr_seed1_seq", 128'(lfsr), 128'(model));
        check_val("lfsr_done_seed1", 128'(lfsr_done), 128'(1));
        $display("[TB] lfsr seed1 state=0x%0h", lfsr);

        // Exponentiator, small prime
        run_vec("p23_b5_e6",  L'(5),  (L+1)'(6),  L'(23), L'(8));
        run_vec("p23_b5_e15", L'(5),  (L+1)'(15), L'(23), L'(19));
        run_vec("dh_b19_e6",  L'(19), (L+1)'(6),  L'(23), L'(2));
        run_vec("dh_b8_e15",  L'(8),  (L+1)'(15), L'(23), L'(2));
        run_vec("exp_zero",   L'(5),  (L+1)'(0),  L'(23), L'(1));
        run_vec("base_gt_p",  L'(28), (L+1)'(2),  L'(23), L'(2));
        run_vec("base_zero",  L'(0),  (L+1)'(5),  L'(23), L'(0));

        // Mersenne prime 2^89-1
        m89 = '0;
        m89[88:0] = '1;
        run_vec("m89_e1",     L'(3), (L+1)'(1),       m89, L'(3));
        run_vec("m89_fermat", L'(3), (L+1)'(m89) - 1, m89, L'(1));

        // Random operands checked against the reference model
        primes[0] = L'(23);
        primes[1] = L'(101);
        primes[2] = L'(65537);
        primes[3] = L'(1000003);
        primes[4] = L'(64'h1FFF_FFFF_FFFF_FFFF);
        for (int i = 0; i < 3; i++) begin
            rp = primes[$urandom_range(0, 4)];
            rb = L'({$urandom(), $urandom(), $urandom(), $urandom()});
            re = (L+1)'($urandom_range(1, 65535));
            run_vec($sformatf("rand%0d", i), rb, re, rp, ref_modexp(rb, re, rp));
        end

        // Abort mid-computation and restart with new operands
        start_op(L'(5), (L+1)'(15), L'(23));
        bad = 0;
        repeat (150) begin
            @(negedge clk);
            if (dirty0 !== 1'b1 || dirty1 !== 1'b1) bad++;
        end
        check_val("abort_dirty_hold", 128'(bad), 128'(0));
        exp_q.push_back(L'(2));
        start_op(L'(19), (L+1)'(6), L'(23));
        wait_done("abort_new", 3, 1'b1);

        // Even modulus: value undefined, but busy must still clear
        start_op(L'(7), (L+1)'(9), L'(22));
        wait_done("even_prime", 4, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
